// File: rtl/axistream_forwarder.sv
// Packet-memory reader: streams len words of the granted buffer out as AXI-Stream, pulses done when the packet has left.
// Latency: first rd_en 1 cycle after the grant, first tvalid 2 cycles later; reads are credit-limited by a 2-entry output buffer.
module axistream_forwarder #(
  parameter int SNOOP_FWD_ADDR_WIDTH = 9,
  parameter int DATA_WIDTH           = 64,
  parameter int PLEN_WIDTH           = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ready_for_forwarder,
  input  logic [PLEN_WIDTH-1:0]           len_to_forwarder,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0] forwarder_rd_addr,
  output logic                            forwarder_rd_en,
  input  logic [DATA_WIDTH-1:0]           forwarder_rd_data,
  output logic                            forwarder_done,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [PLEN_WIDTH-1:0] ONE = 1;

  logic [1:0]            state;
  logic [PLEN_WIDTH-1:0] len_r;
  logic [PLEN_WIDTH-1:0] rd_ptr;
  logic                  in_flight;
  logic                  in_flight_last;

  logic                  head_vld;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] head_dat;
  logic                  tail_vld;
  logic                  tail_last;
  logic [DATA_WIDTH-1:0] tail_dat;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            credit_used;

  assign pop  = head_vld & m_axis_tready;
  assign push = in_flight;

  // Words already buffered plus the one returning this cycle must leave room for the new read.
  assign credit_used = {2'b00, head_vld} + {2'b00, tail_vld} + {2'b00, in_flight};
  assign issue       = (state == STREAM) && (rd_ptr < len_r) &&
                       (credit_used < (3'd2 + {2'b00, pop}));

  assign forwarder_rd_en   = issue;
  assign forwarder_rd_addr = rd_ptr[SNOOP_FWD_ADDR_WIDTH-1:0];
  assign forwarder_done    = (state == DONE);

  assign m_axis_tdata  = head_dat;
  assign m_axis_tvalid = head_vld;
  assign m_axis_tlast  = head_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      len_r          <= '0;
      rd_ptr         <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      in_flight      <= issue;
      in_flight_last <= issue && (rd_ptr == len_r - ONE);
      case (state)
        IDLE: begin
          if (ready_for_forwarder) begin
            len_r  <= len_to_forwarder;
            rd_ptr <= '0;
            state  <= (len_to_forwarder == '0) ? DONE : STREAM;
          end
        end
        STREAM: begin
          if (issue) begin
            rd_ptr <= rd_ptr + ONE;
          end
          if (pop && head_last) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output buffer: head is the stream register, tail only fills while the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_vld  <= 1'b0;
      head_last <= 1'b0;
      head_dat  <= '0;
      tail_vld  <= 1'b0;
      tail_last <= 1'b0;
      tail_dat  <= '0;
    end else if (pop) begin
      if (tail_vld) begin
        head_dat  <= tail_dat;
        head_last <= tail_last;
        tail_vld  <= push;
        if (push) begin
          tail_dat  <= forwarder_rd_data;
          tail_last <= in_flight_last;
        end
      end else begin
        head_vld <= push;
        if (push) begin
          head_dat  <= forwarder_rd_data;
          head_last <= in_flight_last;
        end
      end
    end else if (push) begin
      if (head_vld) begin
        tail_vld  <= 1'b1;
        tail_dat  <= forwarder_rd_data;
        tail_last <= in_flight_last;
      end else begin
        head_vld  <= 1'b1;
        head_dat  <= forwarder_rd_data;
        head_last <= in_flight_last;
      end
    end
  end

endmodule
